// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sdram_arb_pkg;

  localparam int AW_DEF = 24;
  localparam int DW_DEF = 16;

  // Byte select that enables the whole data word.
  localparam logic [1:0] BSEL_WORD = 2'b11;

  typedef enum logic [1:0] {
    CL_NONE = 2'd0,
    CL_VID  = 2'd1,
    CL_CPU  = 2'd2,
    CL_DMA  = 2'd3
  } client_e;

endpackage

// File: rtl/sdram_arb_pick.sv
// Picks the client that owns the next SDRAM slot: video > {cpu, dma}.
// Latency: purely combinational.
// Backpressure: a forced refresh slot yields CL_NONE regardless of requests.
// Ports:
//   vid_req/cpu_req/dma_req - eligible requests (already masked by ack)
//   rr_dma_first            - when cpu and dma both request, give dma the slot
//   refresh_force           - suppress every grant for this slot
//   winner                  - selected client id
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic    vid_req,
  input  logic    cpu_req,
  input  logic    dma_req,
  input  logic    rr_dma_first,
  input  logic    refresh_force,
  output client_e winner
);

  always_comb begin
    winner = CL_NONE;
    if (refresh_force) begin
      winner = CL_NONE;
    end else if (vid_req) begin
      winner = CL_VID;
    end else if (cpu_req && dma_req) begin
      winner = rr_dma_first ? CL_DMA : CL_CPU;
    end else if (cpu_req) begin
      winner = CL_CPU;
    end else if (dma_req) begin
      winner = CL_DMA;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates video/cpu/dma onto the SDRAM controller, one access per slot; routes read data back.
// Latency: ack one clock after cyc_next; read data one slot later, at the end of that slot's cyc cycle.
// Backpressure: clients hold req until ack; every REFRESH_PERIOD busy slots one slot is forced idle.
// Ports:
//   clk, reset (sync, active-high); cyc_next slot pre-strobe
//   vid_*/cpu_*/dma_* client request, ack, rvalid and rdata
//   cyc, REQ, RNW, A, DI, bsel, curr_cpu to the controller; DO read data from it
// Optional: define SDRAM_ARB_RR_EN to alternate cpu/dma when both request in the same slot.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW             = AW_DEF,
  parameter int DW             = DW_DEF,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cyc_next,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_rnw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [1:0]    cpu_be,
  output logic          cpu_ack,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_rnw,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic [1:0]    dma_be,
  output logic          dma_ack,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          cyc,
  output logic          REQ,
  output logic          RNW,
  output logic [AW-1:0] A,
  output logic [DW-1:0] DI,
  output logic [1:0]    bsel,
  output logic          curr_cpu,
  input  logic [DW-1:0] DO
);

  logic          cyc_q, cyc_d, req_q, req_d, rnw_q, rnw_d, curr_cpu_q, curr_cpu_d;
  logic [AW-1:0] a_q, a_d;
  logic [DW-1:0] di_q, di_d;
  logic [1:0]    bsel_q, bsel_d;
  logic          vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
  logic          vid_rvalid_q, vid_rvalid_d, cpu_rvalid_q, cpu_rvalid_d;
  logic          dma_rvalid_q, dma_rvalid_d;
  logic [DW-1:0] vid_rdata_q, vid_rdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic [7:0]    ref_cnt_q, ref_cnt_d;
  client_e       slot_own_q, slot_own_d;  // client of the slot currently on the bus
  client_e       rd_own_q, rd_own_d;      // reader of the previous slot, data due now

  client_e winner;
  logic    refresh_force;
  logic    rr_dma_first;

  assign refresh_force = (ref_cnt_q == 8'(REFRESH_PERIOD));

`ifdef SDRAM_ARB_RR_EN
  // Set once cpu is served so dma goes first next time both compete.
  logic rr_q, rr_d;
  assign rr_dma_first = rr_q;

  always_comb begin
    rr_d = rr_q;
    if (cyc_next) begin
      if (winner == CL_CPU) rr_d = 1'b1;
      else if (winner == CL_DMA) rr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`else
  assign rr_dma_first = 1'b0;
`endif

  // A client whose ack is still high is holding the request just served.
  sdram_arb_pick u_pick (
    .vid_req      (vid_req && !vid_ack_q),
    .cpu_req      (cpu_req && !cpu_ack_q),
    .dma_req      (dma_req && !dma_ack_q),
    .rr_dma_first (rr_dma_first),
    .refresh_force(refresh_force),
    .winner       (winner)
  );

  always_comb begin
    cyc_d        = cyc_next;
    req_d        = req_q;
    rnw_d        = rnw_q;
    a_d          = a_q;
    di_d         = di_q;
    bsel_d       = bsel_q;
    curr_cpu_d   = curr_cpu_q;
    vid_ack_d    = 1'b0;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    vid_rvalid_d = 1'b0;
    cpu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    vid_rdata_d  = vid_rdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    ref_cnt_d    = ref_cnt_q;
    slot_own_d   = slot_own_q;
    rd_own_d     = rd_own_q;

    if (cyc_next) begin
      req_d      = 1'b0;
      curr_cpu_d = 1'b0;
      slot_own_d = winner;
      // A forced refresh yields CL_NONE from the picker, which also clears the counter.
      if (winner == CL_NONE) begin
        ref_cnt_d = '0;
      end else begin
        req_d     = 1'b1;
        ref_cnt_d = ref_cnt_q + 8'd1;
      end
      case (winner)
        CL_VID: begin
          vid_ack_d = 1'b1;
          rnw_d     = 1'b1;
          a_d       = vid_addr;
          bsel_d    = BSEL_WORD;
        end
        CL_CPU: begin
          cpu_ack_d  = 1'b1;
          curr_cpu_d = 1'b1;
          rnw_d      = cpu_rnw;
          a_d        = cpu_addr;
          di_d       = cpu_wdata;
          bsel_d     = cpu_be;
        end
        CL_DMA: begin
          dma_ack_d = 1'b1;
          rnw_d     = dma_rnw;
          a_d       = dma_addr;
          di_d      = dma_wdata;
          bsel_d    = dma_be;
        end
        default: ;
      endcase
    end

    // End of a cyc cycle: hand DO to the previous slot's reader, then remember this slot's reader.
    if (cyc_q) begin
      case (rd_own_q)
        CL_VID: begin vid_rdata_d = DO; vid_rvalid_d = 1'b1; end
        CL_CPU: begin cpu_rdata_d = DO; cpu_rvalid_d = 1'b1; end
        CL_DMA: begin dma_rdata_d = DO; dma_rvalid_d = 1'b1; end
        default: ;
      endcase
      rd_own_d = rnw_q ? slot_own_q : CL_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_q        <= 1'b0;
      req_q        <= 1'b0;
      rnw_q        <= 1'b1;
      a_q          <= '0;
      di_q         <= '0;
      bsel_q       <= BSEL_WORD;
      curr_cpu_q   <= 1'b0;
      vid_ack_q    <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      vid_rvalid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      vid_rdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      ref_cnt_q    <= '0;
      slot_own_q   <= CL_NONE;
      rd_own_q     <= CL_NONE;
    end else begin
      cyc_q        <= cyc_d;
      req_q        <= req_d;
      rnw_q        <= rnw_d;
      a_q          <= a_d;
      di_q         <= di_d;
      bsel_q       <= bsel_d;
      curr_cpu_q   <= curr_cpu_d;
      vid_ack_q    <= vid_ack_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      vid_rvalid_q <= vid_rvalid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      vid_rdata_q  <= vid_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      ref_cnt_q    <= ref_cnt_d;
      slot_own_q   <= slot_own_d;
      rd_own_q     <= rd_own_d;
    end
  end

  assign cyc        = cyc_q;
  assign REQ        = req_q;
  assign RNW        = rnw_q;
  assign A          = a_q;
  assign DI         = di_q;
  assign bsel       = bsel_q;
  assign curr_cpu   = curr_cpu_q;
  assign vid_ack    = vid_ack_q;
  assign cpu_ack    = cpu_ack_q;
  assign dma_ack    = dma_ack_q;
  assign vid_rvalid = vid_rvalid_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign dma_rvalid = dma_rvalid_q;
  assign vid_rdata  = vid_rdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Sits directly upstream of the single-port SDRAM controller.
- Arbitrates three clients onto the controller's request interface, one access per SDRAM cycle slot:
  - video: read-only, highest priority
  - cpu
  - dma
- Drives the controller's cyc/REQ/RNW/A/DI/bsel/curr_cpu, then routes the controller's DO read data back to the client that issued the read.
- Guarantees refresh slots under sustained load.

Parameters:
- AW, 24, word address width (matches controller A).
- DW, 16, data width.
- REFRESH_PERIOD, 64, max consecutive slots with REQ=1 before one slot is forced to REQ=0 (refresh); legal 2..255.

Ports:
- clk  in  1  system clock (same clock as SDRAM controller).
- reset  in  1  synchronous, active-high reset.
- cyc_next  in  1  one-clock pulse, one clock before each controller slot.
- vid_req  in  1  video read request, held until vid_ack.
- vid_addr  in  AW  video word address.
- vid_ack  out  1  one-clock pulse, request issued.
- vid_rvalid  out  1  one-clock pulse, vid_rdata valid.
- vid_rdata  out  DW  video read data.
- cpu_req, cpu_rnw, cpu_addr[AW], cpu_wdata[DW], cpu_be[2]  in  CPU request; byte enables active-high.
- cpu_ack, cpu_rvalid  out  1  as for video.
- cpu_rdata  out  DW  CPU read data.
- dma_req, dma_rnw, dma_addr[AW], dma_wdata[DW], dma_be[2]  in  DMA request.
- dma_ack, dma_rvalid  out  1  as for video.
- dma_rdata  out  DW  DMA read data.
- cyc  out  1  slot strobe to controller.
- REQ, RNW  out  1  controller request / read-not-write.
- A  out  AW  controller address.
- DI  out  DW  controller write data.
- bsel  out  2  controller byte select, active-high.
- curr_cpu  out  1  high when the slot belongs to cpu.
- DO  in  DW  controller read data.

Behaviour:
- Reset values:
  - cyc, REQ, curr_cpu, all acks and rvalids = 0.
  - RNW = 1; A, DI = 0; bsel = 2'b11; rdata regs = 0.
  - In-flight owner = NONE; refresh counter = 0.
- Registered outputs only; cyc <= cyc_next. A/DI/bsel/RNW/REQ/curr_cpu are updated only on the edge where cyc_next=1, so they are stable throughout the cyc cycle.
- Arbitration on the cyc_next edge, among clients with req=1 and not already acked:
  - Order: video > cpu > dma. The Optional Feature changes cpu vs dma.
  - If the refresh counter equals REFRESH_PERIOD, force REQ=0, issue no ack, and clear the counter.
  - Otherwise, winner present: REQ=1 and counter +1. No winner: REQ=0 and counter cleared.
- Winner mapping:
  - video: RNW=1, bsel=11.
  - cpu/dma: RNW=rnw, bsel=be, DI=wdata.
  - A=addr; curr_cpu=1 only for cpu.
- Ack: the winner's ack pulses in the cyc cycle (one clock after cyc_next). The client may change req/addr from the next clock. A req still high at the next cyc_next is a new request.
- Read return:
  - A read issued in slot N records its owner.
  - On the edge ending the cyc cycle of slot N+1, rdata <= DO for that owner and its rvalid pulses for one clock.
  - The owner register then takes slot N+1's read owner, or NONE. One read in flight max; return and a new issue in the same slot are both handled.
- Writes produce no rvalid.
- A pulse on cyc_next without the controller idle is a system error and is not checked here.
- Reset mid-operation: the in-flight read is dropped (no rvalid), and no ack is issued in that slot.

Optional Feature:
- SDRAM_ARB_RR_EN defined: cpu and dma alternate when both request in the same slot. A 1-bit last-served flag toggles only when one of them wins; reset state favours cpu. Video stays highest.
- Undefined: cpu strictly above dma.

Decomposition:
- Package sdram_arb_pkg:
  - client id enum: CL_NONE, CL_VID, CL_CPU, CL_DMA.
  - AW/DW defaults.
  - bsel constant BSEL_WORD=2'b11.
- One combinational sub-module, sdram_arb_pick:
  - Inputs: three req bits, rr flag, refresh-force.
  - Output: winner id.
  - Reused by the bench as the reference model.

Test Plan:
- Single cpu read, addr=24'h012345:
  - cpu_ack in cyc cycle.
  - A=24'h012345, RNW=1, bsel=11, curr_cpu=1.
  - With DO=16'hBEEF at the next slot, cpu_rvalid pulses one clock later with cpu_rdata=16'hBEEF. No vid_rvalid or dma_rvalid.
- Simultaneous vid, cpu and dma reads held for 3 slots:
  - Without RR: grant order vid, cpu, dma.
  - Each rvalid lands at its own owner one slot later.
- cpu write be=2'b01, wdata=16'h00AA:
  - DI=16'h00AA, bsel=01, RNW=0.
  - No rvalid ever.
- REFRESH_PERIOD=4, dma_req held high:
  - Slot REQ pattern 1,1,1,1,0,1,1,1,1,0.
  - dma_ack absent in forced slots.
- SDRAM_ARB_RR_EN, cpu and dma continuously requesting: grants alternate cpu, dma, cpu, dma.
- Reset asserted in the clock after a vid read is issued:
  - No vid_rvalid.
  - All outputs at reset values.
  - The first slot after release issues normally.
